// File: rtl/cpu_pkg.sv
// cpu_pkg: constants shared by the CPU front end.
// Holds the loader FSM encoding and the PC byte step.
package cpu_pkg;
    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        WRITE   = 2'd1,
        FULL    = 2'd2
    } state_t;
    localparam int WORD_BYTES = 4;
    localparam int ADDR_STEP  = 4;
endpackage

// File: rtl/edge_rise.sv
// edge_rise: one-cycle pulse on each 0->1 transition of i_lvl.
module edge_rise (
    input  logic clk,
    input  logic rst,
    input  logic i_lvl,
    output logic o_pulse
);
    logic r_prev;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_prev <= 1'b0;
        else      r_prev <= i_lvl;
    end
    assign o_pulse = i_lvl & ~r_prev;
endmodule

// File: rtl/imem_loader.sv
// imem_loader: assembles switch bytes into 32-bit words and writes them to instruction memory.
// Defining IMEM_LOADER_CKSUM_EN adds a running XOR of accepted words on port cksum.
module imem_loader
    import cpu_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter int                DEPTH     = 64,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        SW,
    input  logic              load_btn,
    input  logic              clr_btn,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    output logic              full,
    output logic [7:0]        LED
`ifdef IMEM_LOADER_CKSUM_EN
    ,
    output logic [31:0]       cksum
`endif
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    state_t            r_state, w_state;
    logic [1:0]        r_lane, w_lane;
    logic [31:0]       r_buf, w_buf;
    logic [ADDR_W-1:0] r_addr, w_addr;
    logic [CNT_W-1:0]  r_cnt, w_cnt;
    logic [3:0]        w_nib;
    logic [7:0]        r_led;
    logic              w_load;
`ifdef IMEM_LOADER_CKSUM_EN
    logic [31:0]       r_cksum, w_cksum;
`else
    logic [3:0]        r_nib;
`endif

    edge_rise u_load (.clk, .rst, .i_lvl(load_btn), .o_pulse(w_load));

    // clr_btn wins over everything, including a pending ack
    always_comb begin
        w_state = r_state;
        w_lane  = r_lane;
        w_buf   = r_buf;
        w_addr  = r_addr;
        w_cnt   = r_cnt;
`ifdef IMEM_LOADER_CKSUM_EN
        w_cksum = r_cksum;
`else
        w_nib   = r_nib;
`endif
        if (clr_btn) begin
            w_state = COLLECT;
            w_lane  = '0;
            w_buf   = '0;
            w_addr  = BASE_ADDR;
            w_cnt   = '0;
`ifdef IMEM_LOADER_CKSUM_EN
            w_cksum = '0;
`endif
        end else if (r_state == COLLECT && w_load) begin
            w_buf[{r_lane, 3'b000} +: 8] = SW;
            w_lane  = r_lane + 2'd1;
            w_state = (r_lane == 2'(WORD_BYTES - 1)) ? WRITE : COLLECT;
`ifndef IMEM_LOADER_CKSUM_EN
            w_nib   = SW[3:0];
`endif
        end else if (r_state == WRITE && mem_ack) begin
            w_lane  = '0;
            w_buf   = '0;
            w_addr  = r_addr + ADDR_W'(ADDR_STEP);
            w_cnt   = r_cnt + 1'b1;
            w_state = (w_cnt == CNT_W'(DEPTH)) ? FULL : COLLECT;
`ifdef IMEM_LOADER_CKSUM_EN
            w_cksum = r_cksum ^ r_buf;
`endif
        end
    end

`ifdef IMEM_LOADER_CKSUM_EN
    assign w_nib = w_cksum[3:0];
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= COLLECT;
            r_lane  <= '0;
            r_buf   <= '0;
            r_addr  <= BASE_ADDR;
            r_cnt   <= '0;
            r_led   <= '0;
`ifdef IMEM_LOADER_CKSUM_EN
            r_cksum <= '0;
`else
            r_nib   <= '0;
`endif
        end else begin
            r_state <= w_state;
            r_lane  <= w_lane;
            r_buf   <= w_buf;
            r_addr  <= w_addr;
            r_cnt   <= w_cnt;
            r_led   <= {w_lane, w_state == WRITE, w_state == FULL, w_nib};
`ifdef IMEM_LOADER_CKSUM_EN
            r_cksum <= w_cksum;
`else
            r_nib   <= w_nib;
`endif
        end
    end

    assign mem_we    = (r_state == WRITE);
    assign full      = (r_state == FULL);
    assign mem_addr  = r_addr;
    assign mem_wdata = r_buf;
    assign LED       = r_led;
`ifdef IMEM_LOADER_CKSUM_EN
    assign cksum     = r_cksum;
`endif
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: table-driven check of imem_loader (DEPTH=2) plus reset and checksum sequences.
module tb_imem_loader;
    logic        clk = 1'b0;
    logic        rst, load_btn, clr_btn, mem_ack, mem_we, full;
    logic [7:0]  SW, LED;
    logic [31:0] mem_addr, mem_wdata;
`ifdef IMEM_LOADER_CKSUM_EN
    logic [31:0] cksum;
    localparam logic [7:0] LED_M = 8'hF0;
`else
    localparam logic [7:0] LED_M = 8'hFF;
`endif
    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic        ld;
        logic [7:0]  sw;
        logic        clr;
        logic        ack;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wd;
        logic        fl;
        logic [7:0]  led;
    } vec_t;
    vec_t tv[$];

    imem_loader #(.ADDR_W(32), .DEPTH(2), .BASE_ADDR(32'h0)) dut (
        .clk(clk), .rst(rst), .SW(SW), .load_btn(load_btn), .clr_btn(clr_btn),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .full(full), .LED(LED)
`ifdef IMEM_LOADER_CKSUM_EN
        , .cksum(cksum)
`endif
    );

    always #5 clk = ~clk;

    task automatic v(input logic ld, input logic [7:0] sw, input logic clr, input logic ack,
                     input logic we, input logic [31:0] addr, input logic [31:0] wd,
                     input logic fl, input logic [7:0] led);
        vec_t t;
        t = '{ld, sw, clr, ack, we, addr, wd, fl, led};
        tv.push_back(t);
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [7:0] b);
        SW = b;
        load_btn = 1'b1;
        step();
        load_btn = 1'b0;
        step();
    endtask

    initial begin
        logic [73:0] got, exp;
        rst = 1'b0; load_btn = 1'b0; clr_btn = 1'b0; mem_ack = 1'b0; SW = 8'h00;
        // word 0x00000013 with ack tied high: one write cycle, then address 4
        v(1,8'h13,0,1, 0,32'h0,32'h0,0,8'h43); v(0,8'h00,0,1, 0,32'h0,32'h0,0,8'h43);
        v(1,8'h00,0,1, 0,32'h0,32'h0,0,8'h80); v(0,8'h00,0,1, 0,32'h0,32'h0,0,8'h80);
        v(1,8'h00,0,1, 0,32'h0,32'h0,0,8'hC0); v(0,8'h00,0,1, 0,32'h0,32'h0,0,8'hC0);
        v(1,8'h00,0,1, 1,32'h0,32'h13,0,8'h20); v(0,8'h00,0,1, 0,32'h4,32'h0,0,8'h00);
        // word 0x12345678, ack after six write cycles, extra presses ignored, then FULL
        v(1,8'h78,0,0, 0,32'h4,32'h0,0,8'h48); v(0,8'h00,0,0, 0,32'h4,32'h0,0,8'h48);
        v(1,8'h56,0,0, 0,32'h4,32'h0,0,8'h86); v(0,8'h00,0,0, 0,32'h4,32'h0,0,8'h86);
        v(1,8'h34,0,0, 0,32'h4,32'h0,0,8'hC4); v(0,8'h00,0,0, 0,32'h4,32'h0,0,8'hC4);
        v(1,8'h12,0,0, 1,32'h4,32'h12345678,0,8'h22); v(0,8'h00,0,0, 1,32'h4,32'h12345678,0,8'h22);
        v(1,8'hAA,0,0, 1,32'h4,32'h12345678,0,8'h22); v(0,8'h00,0,0, 1,32'h4,32'h12345678,0,8'h22);
        v(1,8'hBB,0,0, 1,32'h4,32'h12345678,0,8'h22); v(0,8'h00,0,0, 1,32'h4,32'h12345678,0,8'h22);
        v(0,8'h00,0,1, 0,32'h8,32'h0,1,8'h12);
        // presses while FULL are ignored; clr leaves FULL
        v(1,8'h11,0,0, 0,32'h8,32'h0,1,8'h12); v(0,8'h00,0,0, 0,32'h8,32'h0,1,8'h12);
        v(1,8'h22,0,0, 0,32'h8,32'h0,1,8'h12); v(0,8'h00,0,0, 0,32'h8,32'h0,1,8'h12);
        v(0,8'h00,1,0, 0,32'h0,32'h0,0,8'h02);
        // clr together with a load event mid-word, then a fresh word
        v(1,8'h01,0,0, 0,32'h0,32'h0,0,8'h41); v(0,8'h00,0,0, 0,32'h0,32'h0,0,8'h41);
        v(1,8'h02,0,0, 0,32'h0,32'h0,0,8'h82); v(0,8'h00,0,0, 0,32'h0,32'h0,0,8'h82);
        v(1,8'h03,1,0, 0,32'h0,32'h0,0,8'h02); v(0,8'h00,0,0, 0,32'h0,32'h0,0,8'h02);
        v(1,8'hA1,0,0, 0,32'h0,32'h0,0,8'h41); v(0,8'h00,0,0, 0,32'h0,32'h0,0,8'h41);
        v(1,8'hB2,0,0, 0,32'h0,32'h0,0,8'h82); v(0,8'h00,0,0, 0,32'h0,32'h0,0,8'h82);
        v(1,8'hC3,0,0, 0,32'h0,32'h0,0,8'hC3); v(0,8'h00,0,0, 0,32'h0,32'h0,0,8'hC3);
        v(1,8'hD4,0,0, 1,32'h0,32'hD4C3B2A1,0,8'h24);
        // clr abandons the write despite ack; a stray ack afterwards does nothing
        v(0,8'h00,1,1, 0,32'h0,32'h0,0,8'h04); v(0,8'h00,0,1, 0,32'h0,32'h0,0,8'h04);

        #3;
        check("reset_we", {31'h0, mem_we}, 32'h0);
        check("reset_addr", mem_addr, 32'h0);
        check("reset_wdata", mem_wdata, 32'h0);
        check("reset_full_led", {23'h0, full, LED}, 32'h0);
        #4 rst = 1'b1;

        for (int i = 0; i < tv.size(); i++) begin
            load_btn = tv[i].ld; SW = tv[i].sw; clr_btn = tv[i].clr; mem_ack = tv[i].ack;
            @(posedge clk);
            #1;
            got = {mem_we, mem_addr, tv[i].we ? mem_wdata : 32'h0, full, LED & LED_M};
            exp = {tv[i].we, tv[i].addr, tv[i].we ? tv[i].wd : 32'h0, tv[i].fl, tv[i].led & LED_M};
            n_vec++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL vec%0d: got we/addr/wdata/full/led=%h expected %h", i, got, exp);
            end
        end

        // asynchronous reset between edges while a write is pending
        load_btn = 1'b0; clr_btn = 1'b0; mem_ack = 1'b0;
        press(8'h01); press(8'h02); press(8'h03); press(8'h04);
        check("pre_rst_we", {31'h0, mem_we}, 32'h1);
        check("pre_rst_wdata", mem_wdata, 32'h04030201);
        #3 rst = 1'b0;
        #1;
        check("async_rst_we", {31'h0, mem_we}, 32'h0);
        check("async_rst_addr", mem_addr, 32'h0);
        check("async_rst_wdata", mem_wdata, 32'h0);
        check("async_rst_full_led", {23'h0, full, LED}, 32'h0);
        #2 rst = 1'b1;
        step();
        check("post_rst_led", {24'h0, LED}, 32'h0);
        press(8'h13); press(8'h00); press(8'h00); press(8'h00);
        check("post_rst_write", {mem_we, mem_addr[30:0]}, 32'h80000000);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        check("post_rst_next_addr", mem_addr, 32'h4);

`ifdef IMEM_LOADER_CKSUM_EN
        clr_btn = 1'b1;
        step();
        clr_btn = 1'b0;
        check("cksum_clr0", cksum, 32'h0);
        press(8'h00); press(8'h00); press(8'hFF); press(8'hFF);
        check("cksum_w0", mem_wdata, 32'hFFFF0000);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        check("cksum_1", cksum, 32'hFFFF0000);
        press(8'h0F); press(8'h0F); press(8'h0F); press(8'h0F);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        check("cksum_2", cksum, 32'hF0F00F0F);
        check("cksum_led", {28'h0, LED[3:0]}, 32'hF);
        check("cksum_full", {31'h0, full}, 32'h1);
        clr_btn = 1'b1;
        step();
        clr_btn = 1'b0;
        check("cksum_clr", cksum, 32'h0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction-fetch path: the fetch stage reads 32-bit words from instruction memory at the PC; this block fills that memory from board switches.
- The user keys in one byte on SW[7:0] and presses the load key; four bytes, least-significant first, make one word.
- Each word is written to the next sequential byte address (step 4), matching the PC convention.
- LED shows the byte lane, the last byte and the full/busy status, so a program can be loaded and checked before the CPU runs.

Parameters:
- ADDR_W, 32, width of the byte address bus mem_addr.
- DEPTH, 64, number of words that can be loaded before FULL.
- BASE_ADDR, 32'h0000_0000, byte address of the first word; must be 4-aligned.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-low reset.
- SW  input  8  byte value to capture.
- load_btn  input  1  load key, synchronous level; each 0->1 edge captures SW.
- clr_btn  input  1  synchronous level; 1 aborts the partial word and rewinds the address to BASE_ADDR.
- mem_we  output  1  write request, held until acknowledged.
- mem_addr  output  ADDR_W  byte address of the word being written.
- mem_wdata  output  32  assembled word.
- mem_ack  input  1  memory accepted the write in this cycle.
- full  output  1  DEPTH words have been written.
- LED  output  8  status display, defined below.

Behaviour:
- Reset (rst=0, asynchronous): state=COLLECT, lane=0, word buffer=0, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, full=0, LED=0, load-edge register=0, word count=0.
- Edge detect: a load event is load_btn=1 while the previous-cycle sample was 0. There is exactly one event per press. No debounce is done here.
- COLLECT:
  - On a load event, write SW into buffer[8*lane+7 : 8*lane], then lane++.
  - When the event fills lane 3, go to WRITE next cycle. mem_wdata = full buffer, mem_we=1, and mem_addr is unchanged.
- WRITE:
  - mem_we, mem_addr and mem_wdata hold stable until mem_ack=1 is sampled.
  - On that same edge: mem_we=0, mem_addr += 4 (wraps modulo 2^ADDR_W), count++, lane=0, buffer=0.
  - Next state is FULL if count reaches DEPTH, otherwise COLLECT.
  - Load events are ignored while in WRITE, and the edge register still updates.
  - mem_ack while mem_we=0 is ignored.
- FULL: full=1 and load events are ignored. Only clr_btn or reset leaves this state.
- clr_btn=1 (any state, takes priority over a load event in the same cycle):
  - Next cycle: state=COLLECT, lane=0, buffer=0, mem_we=0, mem_addr=BASE_ADDR, count=0, full=0.
  - A write in progress is abandoned, even if mem_ack=1 in the same cycle.
- Latency:
  - 4th load event -> mem_we=1 on the next clock edge.
  - mem_ack -> mem_we=0 and the new address on the same edge.
- LED (registered):
  - LED[7:6] = lane.
  - LED[5] = mem_we.
  - LED[4] = full.
  - LED[3:0] = low nibble of the last captured byte.
- Reset in the middle of a word or write discards everything and returns to the reset values.

Optional Feature:
- Macro IMEM_LOADER_CKSUM_EN.
- When defined:
  - A 32-bit register cksum is added, reset to 0 and cleared by clr_btn.
  - On each accepted write (mem_ack while in WRITE) it takes cksum XOR mem_wdata.
  - Extra output port cksum[31:0].
  - LED[3:0] shows cksum[3:0] instead of the last byte.
- When undefined: no cksum port and no register; LED is as above.

Decomposition:
- Shared package cpu_pkg holds:
  - state encoding (COLLECT=2'd0, WRITE=2'd1, FULL=2'd2);
  - WORD_BYTES=4;
  - the byte-address step constant 4, which the PC logic also uses.
- One sub-module, edge_rise, produces the registered 0->1 pulse for load_btn.
- The FSM, buffer and counters stay in imem_loader.

Test Plan:
- Bytes 0x13,0x00,0x00,0x00 with mem_ack tied to 1 -> one cycle of mem_we at mem_addr=0 with wdata=0x0000_0013; the next word goes to address 4.
- Bytes 0x78,0x56,0x34,0x12 with mem_ack delayed 5 cycles -> mem_we/addr/wdata stable for 6 cycles, wdata=0x1234_5678; extra load presses during the wait are ignored and lane stays 0 afterwards.
- Two bytes entered, then clr_btn=1 together with a load event -> lane=0, addr=BASE_ADDR; the next four bytes form a fresh word.
- DEPTH=2: load 3 words -> full=1 after the second ack at addr=8; the third word's presses leave lane and LED[7:6] at 0; clr_btn clears full.
- rst pulsed low asynchronously between clock edges while mem_we=1 -> mem_we=0 immediately and all outputs at reset values.
- With IMEM_LOADER_CKSUM_EN: write 0xFFFF_0000, then 0x0F0F_0F0F -> cksum=0xF0F0_0F0F; clr_btn -> 0.
